// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the RV32I instruction-fetch stage: bubble encoding,
// PC step and the fetch FSM state type.
package if_fetch_unit_pkg;

    localparam logic [31:0] RV32I_NOP = 32'h0000_0013;  // ADDI x0,x0,0
    localparam int unsigned PC_STEP   = 4;

    typedef enum logic [1:0] {
        S_FETCH,
        S_HOLD,
        S_DRAIN
    } fetch_state_t;

endpackage

// File: rtl/if_hold_buffer.sv
// One-entry skid register that parks a fetched PC/instruction pair while
// decode is stalled; clear has priority over load.
module if_hold_buffer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_pc,
    input  logic [WIDTH-1:0] load_instr,
    output logic             valid,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] instr
);

    // NOTE: only the valid flag needs a reset; the payload is never consumed
    // while valid is low, so leaving it unreset is safe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load && !clear) begin
            pc    <= load_pc;
            instr <= load_instr;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// RV32I instruction-fetch stage: owns the fetch PC, keeps one request in flight
// to instruction memory and drives the IF->ID register with bubbles when empty.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned                REG_DATA_WIDTH = 32,
    parameter logic [REG_DATA_WIDTH-1:0] RESET_PC       = '0,
    parameter logic [REG_DATA_WIDTH-1:0] NOP_INSTR      = RV32I_NOP
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      ID_Stall,
    input  logic                      EX_Redirect,
    input  logic [REG_DATA_WIDTH-1:0] EX_PC_dest,
    output logic                      IMem_req,
    output logic [REG_DATA_WIDTH-1:0] IMem_addr,
    input  logic                      IMem_ack,
    input  logic [REG_DATA_WIDTH-1:0] IMem_rdata,
    output logic [REG_DATA_WIDTH-1:0] IF_PC,
    output logic [REG_DATA_WIDTH-1:0] IF_Instruction,
    output logic                      IF_Valid
);

    fetch_state_t              state;
    logic [REG_DATA_WIDTH-1:0] fetch_pc;
    logic [REG_DATA_WIDTH-1:0] fetch_pc_next;
    logic [REG_DATA_WIDTH-1:0] redirect_pc;
    logic                      ack_taken;
    logic                      hold_load;
    logic                      hold_clear;
    logic                      hold_valid;
    logic [REG_DATA_WIDTH-1:0] hold_pc;
    logic [REG_DATA_WIDTH-1:0] hold_instr;

    assign fetch_pc_next = fetch_pc + REG_DATA_WIDTH'(PC_STEP);
    assign redirect_pc   = {EX_PC_dest[REG_DATA_WIDTH-1:2], 2'b00};
    assign ack_taken     = IMem_req && IMem_ack;
    assign hold_load     = !EX_Redirect && (state == S_FETCH) && ack_taken && ID_Stall;
    assign hold_clear    = EX_Redirect || ((state == S_HOLD) && !ID_Stall);

    if_hold_buffer #(
        .WIDTH(REG_DATA_WIDTH)
    ) u_hold (
        .clk       (Clk),
        .rst       (Reset),
        .load      (hold_load),
        .clear     (hold_clear),
        .load_pc   (fetch_pc),
        .load_instr(IMem_rdata),
        .valid     (hold_valid),
        .pc        (hold_pc),
        .instr     (hold_instr)
    );

    // NOTE: every register here is sequential state, so all updates use
    // non-blocking assignments; blocking ones would race with the readers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state          <= S_FETCH;
            fetch_pc       <= RESET_PC;
            IMem_req       <= 1'b0;
            IMem_addr      <= RESET_PC;
            IF_PC          <= '0;
            IF_Instruction <= NOP_INSTR;
            IF_Valid       <= 1'b0;
        end else if (EX_Redirect) begin
            fetch_pc       <= redirect_pc;
            IF_Instruction <= NOP_INSTR;
            IF_Valid       <= 1'b0;
            unique case (state)
                S_FETCH: begin
                    // A request still in flight must complete before the new target is issued.
                    if (IMem_req && !IMem_ack) begin
                        state <= S_DRAIN;
                    end else begin
                        IMem_req  <= 1'b1;
                        IMem_addr <= redirect_pc;
                    end
                end
                S_HOLD: begin
                    state     <= S_FETCH;
                    IMem_req  <= 1'b1;
                    IMem_addr <= redirect_pc;
                end
                default: ;
            endcase
        end else begin
            unique case (state)
                S_FETCH: begin
                    IMem_req <= 1'b1;
                    if (ack_taken && !ID_Stall) begin
                        IF_PC          <= fetch_pc;
                        IF_Instruction <= IMem_rdata;
                        IF_Valid       <= 1'b1;
                        fetch_pc       <= fetch_pc_next;
                        IMem_addr      <= fetch_pc_next;
                    end else if (ack_taken) begin
                        IMem_req <= 1'b0;
                        state    <= S_HOLD;
                    end else if (!ID_Stall) begin
                        IF_Instruction <= NOP_INSTR;
                        IF_Valid       <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!ID_Stall) begin
                        IF_PC          <= hold_pc;
                        IF_Instruction <= hold_instr;
                        IF_Valid       <= hold_valid;
                        fetch_pc       <= fetch_pc_next;
                        IMem_addr      <= fetch_pc_next;
                        IMem_req       <= 1'b1;
                        state          <= S_FETCH;
                    end
                end
                default: begin
                    if (IMem_ack) begin
                        IMem_addr <= fetch_pc;
                        state     <= S_FETCH;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit: zero-wait and slow memory,
// decode stalls, redirects (with and without a pending request), PC wrap, reset in drain.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        ID_Stall = 1'b0;
    logic        EX_Redirect = 1'b0;
    logic [31:0] EX_PC_dest = '0;
    logic        IMem_req;
    logic [31:0] IMem_addr;
    logic        IMem_ack;
    logic [31:0] IMem_rdata;
    logic [31:0] IF_PC;
    logic [31:0] IF_Instruction;
    logic        IF_Valid;
    logic        ack_en = 1'b1;

    logic        rst_w = 1'b0;
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_pc;
    logic [31:0] w_instr;
    logic        w_valid;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    // Memory model: returns its address as data; acks whenever enabled and requested.
    assign IMem_ack   = ack_en && IMem_req;
    assign IMem_rdata = IMem_addr;

    if_fetch_unit dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .ID_Stall      (ID_Stall),
        .EX_Redirect   (EX_Redirect),
        .EX_PC_dest    (EX_PC_dest),
        .IMem_req      (IMem_req),
        .IMem_addr     (IMem_addr),
        .IMem_ack      (IMem_ack),
        .IMem_rdata    (IMem_rdata),
        .IF_PC         (IF_PC),
        .IF_Instruction(IF_Instruction),
        .IF_Valid      (IF_Valid)
    );

    if_fetch_unit #(
        .RESET_PC(32'hFFFF_FFF8)
    ) dut_wrap (
        .Clk           (Clk),
        .Reset         (rst_w),
        .ID_Stall      (1'b0),
        .EX_Redirect   (1'b0),
        .EX_PC_dest    (32'h0),
        .IMem_req      (w_req),
        .IMem_addr     (w_addr),
        .IMem_ack      (w_req),
        .IMem_rdata    (w_addr),
        .IF_PC         (w_pc),
        .IF_Instruction(w_instr),
        .IF_Valid      (w_valid)
    );

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset       = 1'b1;
        ID_Stall    = 1'b0;
        EX_Redirect = 1'b0;
        ack_en      = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        #1 Reset = 1'b1;
        rst_w = 1'b1;
        #1;
        checks++; if (IMem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", IMem_req); end
        checks++; if (IMem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 00000000", IMem_addr); end
        checks++; if (IF_PC !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000000", IF_PC); end
        checks++; if (IF_Instruction !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", IF_Instruction, NOP); end
        checks++; if (IF_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", IF_Valid); end
        @(negedge Clk);
        Reset = 1'b0;
        tick();
        checks++; if (IMem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", IMem_req); end
        checks++; if (IMem_addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h want 00000000", IMem_addr); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp;
        do_reset();
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            exp = 32'(4 * i);
            checks++; if (IF_PC !== exp) begin errors++; $display("FAIL zw_pc[%0d]: got %h want %h", i, IF_PC, exp); end
            checks++; if (IF_Instruction !== exp) begin errors++; $display("FAIL zw_instr[%0d]: got %h want %h", i, IF_Instruction, exp); end
            checks++; if (IF_Valid !== 1'b1) begin errors++; $display("FAIL zw_valid[%0d]: got %b want 1", i, IF_Valid); end
        end
    endtask

    task automatic test_slow_mem();
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
        logic        exp_valid;
        do_reset();
        ack_en = 1'b0;
        tick();
        for (int c = 0; c < 9; c++) begin
            ack_en = (c % 3 == 2);
            tick();
            exp_valid = (c % 3 == 2);
            exp_pc    = 32'(4 * (c / 3));
            exp_addr  = exp_valid ? 32'(4 * (c / 3 + 1)) : 32'(4 * (c / 3));
            checks++; if (IF_Valid !== exp_valid) begin errors++; $display("FAIL slow_valid[%0d]: got %b want %b", c, IF_Valid, exp_valid); end
            checks++; if (IMem_addr !== exp_addr) begin errors++; $display("FAIL slow_addr[%0d]: got %h want %h", c, IMem_addr, exp_addr); end
            if (exp_valid) begin
                checks++; if (IF_PC !== exp_pc) begin errors++; $display("FAIL slow_pc[%0d]: got %h want %h", c, IF_PC, exp_pc); end
            end else begin
                checks++; if (IF_Instruction !== NOP) begin errors++; $display("FAIL slow_nop[%0d]: got %h want %h", c, IF_Instruction, NOP); end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        tick();
        tick();
        ID_Stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (IMem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d]: got %b want 0", i, IMem_req); end
            checks++; if (IF_PC !== 32'h4) begin errors++; $display("FAIL stall_pc[%0d]: got %h want 00000004", i, IF_PC); end
            checks++; if (IF_Valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, IF_Valid); end
        end
        ID_Stall = 1'b0;
        tick();
        checks++; if (IF_PC !== 32'h8) begin errors++; $display("FAIL release_pc: got %h want 00000008", IF_PC); end
        checks++; if (IF_Instruction !== 32'h8) begin errors++; $display("FAIL release_instr: got %h want 00000008", IF_Instruction); end
        checks++; if (IMem_req !== 1'b1) begin errors++; $display("FAIL release_req: got %b want 1", IMem_req); end
        tick();
        checks++; if (IF_PC !== 32'hC) begin errors++; $display("FAIL release_next_pc: got %h want 0000000c", IF_PC); end
        checks++; if (IF_Valid !== 1'b1) begin errors++; $display("FAIL release_next_valid: got %b want 1", IF_Valid); end
    endtask

    task automatic test_redirect_drain();
        do_reset();
        ack_en = 1'b0;
        tick();
        EX_Redirect = 1'b1;
        EX_PC_dest  = 32'h103;
        tick();
        EX_Redirect = 1'b0;
        checks++; if (IMem_addr !== 32'h0) begin errors++; $display("FAIL drain_stale_addr: got %h want 00000000", IMem_addr); end
        checks++; if (IMem_req !== 1'b1) begin errors++; $display("FAIL drain_req: got %b want 1", IMem_req); end
        checks++; if (IF_Valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", IF_Valid); end
        ack_en = 1'b1;
        tick();
        checks++; if (IMem_addr !== 32'h100) begin errors++; $display("FAIL drain_new_addr: got %h want 00000100", IMem_addr); end
        checks++; if (IF_Valid !== 1'b0) begin errors++; $display("FAIL drain_dropped: got %b want 0", IF_Valid); end
        tick();
        checks++; if (IF_PC !== 32'h100) begin errors++; $display("FAIL target_pc: got %h want 00000100", IF_PC); end
        checks++; if (IF_Valid !== 1'b1) begin errors++; $display("FAIL target_valid: got %b want 1", IF_Valid); end
        tick();
        checks++; if (IF_PC !== 32'h104) begin errors++; $display("FAIL target_next_pc: got %h want 00000104", IF_PC); end
    endtask

    task automatic test_back_to_back_redirect();
        do_reset();
        tick();
        tick();
        tick();
        EX_Redirect = 1'b1;
        EX_PC_dest  = 32'h200;
        tick();
        EX_Redirect = 1'b0;
        checks++; if (IF_Valid !== 1'b0) begin errors++; $display("FAIL b2b_bubble: got %b want 0", IF_Valid); end
        checks++; if (IMem_addr !== 32'h200) begin errors++; $display("FAIL b2b_addr: got %h want 00000200", IMem_addr); end
        tick();
        checks++; if (IF_PC !== 32'h200) begin errors++; $display("FAIL b2b_pc: got %h want 00000200", IF_PC); end
        checks++; if (IF_Valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", IF_Valid); end
    endtask

    task automatic test_wrap();
        @(negedge Clk);
        rst_w = 1'b0;
        tick();
        checks++; if (w_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_first_addr: got %h want fffffff8", w_addr); end
        tick();
        checks++; if (w_pc !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_pc0: got %h want fffffff8", w_pc); end
        tick();
        checks++; if (w_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc1: got %h want fffffffc", w_pc); end
        checks++; if (w_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 00000000", w_addr); end
        tick();
        checks++; if (w_pc !== 32'h0) begin errors++; $display("FAIL wrap_pc2: got %h want 00000000", w_pc); end
        checks++; if (w_instr !== 32'h0) begin errors++; $display("FAIL wrap_instr2: got %h want 00000000", w_instr); end
        checks++; if (w_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b want 1", w_valid); end
    endtask

    task automatic test_reset_in_drain();
        do_reset();
        tick();
        tick();
        tick();
        ack_en      = 1'b0;
        EX_Redirect = 1'b1;
        EX_PC_dest  = 32'h300;
        tick();
        EX_Redirect = 1'b0;
        checks++; if (IMem_addr !== 32'h8) begin errors++; $display("FAIL rd_stale_addr: got %h want 00000008", IMem_addr); end
        checks++; if (IF_PC !== 32'h4) begin errors++; $display("FAIL rd_pc_held: got %h want 00000004", IF_PC); end
        Reset = 1'b1;
        #1;
        checks++; if (IMem_req !== 1'b0) begin errors++; $display("FAIL rd_req: got %b want 0", IMem_req); end
        checks++; if (IMem_addr !== 32'h0) begin errors++; $display("FAIL rd_addr: got %h want 00000000", IMem_addr); end
        checks++; if (IF_PC !== 32'h0) begin errors++; $display("FAIL rd_pc: got %h want 00000000", IF_PC); end
        checks++; if (IF_Instruction !== NOP) begin errors++; $display("FAIL rd_instr: got %h want %h", IF_Instruction, NOP); end
        checks++; if (IF_Valid !== 1'b0) begin errors++; $display("FAIL rd_valid: got %b want 0", IF_Valid); end
        Reset  = 1'b0;
        ack_en = 1'b1;
        tick();
        checks++; if (IMem_addr !== 32'h0) begin errors++; $display("FAIL rd_refetch_addr: got %h want 00000000", IMem_addr); end
        tick();
        checks++; if (IF_PC !== 32'h0) begin errors++; $display("FAIL rd_refetch_pc: got %h want 00000000", IF_PC); end
        checks++; if (IF_Valid !== 1'b1) begin errors++; $display("FAIL rd_refetch_valid: got %b want 1", IF_Valid); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_slow_mem();
        test_stall();
        test_redirect_drain();
        test_back_to_back_redirect();
        test_wrap();
        test_reset_in_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
